// File: rtl/rr_arb_mux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb_mux_pkg: lock-state encoding and one-hot rotate helper     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rr_arb_mux_pkg;

  localparam int MAX_CH = 32;
  localparam int IDX_W  = 5;

  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Rotates the low n bits of a one-hot vector left by one position.
  function automatic logic [MAX_CH-1:0] rotl_oh(input logic [MAX_CH-1:0] vec,
                                                input int unsigned     n);
    logic [MAX_CH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (i < n) r[IDX_W'((i + 1) % n)] = vec[IDX_W'(i)];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_mux_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb_mux_if: input/output handshake bundle of rr_arb_mux        |
// | Optional last signals under RR_ARB_MUX_LOCK_EN.  Rev 1.0          |
// +------------------------------------------------------------------+
interface rr_arb_mux_if #(
  parameter type T      = logic [7:0],
  parameter int  NUM_CH = 4
);
  logic [NUM_CH-1:0] in_valid_i;
  logic [NUM_CH-1:0] in_ready_o;
  T     [NUM_CH-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  T                  out_data_o;
  logic [NUM_CH-1:0] out_sel_oh_o;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [NUM_CH-1:0] in_last_i;
  logic              out_last_o;

  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_sel_oh_o, out_last_o
  );
  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_sel_oh_o, out_last_o
  );
`else
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_sel_oh_o
  );
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_sel_oh_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rr_arb_mux_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin one-hot arbiter             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] ptr_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic [NUM_CH-1:0] gnt_o
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [2*NUM_CH-1:0] gnt_dbl;

  // Subtracting the pointer from the doubled request isolates the first
  // request at or above the pointer; the upper copy supplies the wrap.
  always_comb begin
    req_dbl = {req_i & mask_i, req_i & mask_i};
    gnt_dbl = req_dbl & ~(req_dbl - {{NUM_CH{1'b0}}, ptr_i});
    gnt_o   = gnt_dbl[NUM_CH-1:0] | gnt_dbl[2*NUM_CH-1:NUM_CH];
  end

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb_mux: registered round-robin N:1 arbitrating multiplexer    |
// | Packet lock enabled by RR_ARB_MUX_LOCK_EN.  Rev 1.0               |
// +------------------------------------------------------------------+
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter type T      = logic [7:0],
  parameter int  NUM_CH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  rr_arb_mux_if.slave   bus
);

  localparam int DW = $bits(T);

  logic              load;
  logic              xfer;
  logic              last_sel;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] arb_gnt;
  logic [NUM_CH-1:0] grant;
  logic [DW-1:0]     sel_data;

  logic [NUM_CH-1:0] ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  T                  out_data_q, out_data_d;
  logic [NUM_CH-1:0] out_sel_q, out_sel_d;

`ifdef RR_ARB_MUX_LOCK_EN
  lock_state_e       lock_q, lock_d;
  logic [NUM_CH-1:0] lock_oh_q, lock_oh_d;
  logic              out_last_q, out_last_d;

  always_comb begin
    mask = (lock_q == LOCK_HELD) ? lock_oh_q : '1;
  end
`else
  always_comb begin
    mask = '1;
  end
`endif

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i  (bus.in_valid_i),
    .ptr_i  (ptr_q),
    .mask_i (mask),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    load  = !out_valid_q || bus.out_ready_i;
    grant = (load && rst_ni) ? arb_gnt : '0;
    xfer  = |grant;
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_data = sel_data | (bus.in_data_i[k] & {DW{grant[k]}});
    end
`ifdef RR_ARB_MUX_LOCK_EN
    last_sel = |(bus.in_last_i & grant);
`else
    // Without packet locking each beat is a packet of its own.
    last_sel = 1'b1;
`endif
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer && last_sel) ptr_d = NUM_CH'(rotl_oh(MAX_CH'(grant), NUM_CH));
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = T'(sel_data);
      out_sel_d  = grant;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_oh_d  = lock_oh_q;
    out_last_d = out_last_q;
    if (xfer) out_last_d = last_sel;
    case (lock_q)
      LOCK_IDLE: if (xfer && !last_sel) begin
        lock_d    = LOCK_HELD;
        lock_oh_d = grant;
      end
      LOCK_HELD: if (xfer && last_sel) lock_d = LOCK_IDLE;
      default:   lock_d = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= LOCK_IDLE;
      lock_oh_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_oh_q  <= lock_oh_d;
      out_last_q <= out_last_d;
    end
  end

  assign bus.out_last_o = out_last_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= NUM_CH'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready_o   = grant;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.out_sel_oh_o = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rr_arb_mux: scoreboard bench for rr_arb_mux (4-ch and 1-ch)    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_rr_arb_mux;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] sel;
    logic       last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t q0[$];
  logic [7:0] q1[$];
  exp_t mon_e;
  logic [7:0] mon_d;
  bit   acc;
  int   waitc;

  rr_arb_mux_if #(.T(logic [7:0]), .NUM_CH(4)) if0 ();
  rr_arb_mux_if #(.T(logic [7:0]), .NUM_CH(1)) if1 ();

  rr_arb_mux #(.T(logic [7:0]), .NUM_CH(4)) u_dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if0)
  );

  rr_arb_mux #(.T(logic [7:0]), .NUM_CH(1)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already driven; check the grant and queue the beat it produces.
  task automatic expect_grant(input logic [3:0] rdy, input logic [7:0] d, input logic l);
    @(negedge clk);
    chk("in_ready", 32'(if0.in_ready_o), 32'(rdy));
    if (rdy != 4'b0000) q0.push_back('{data: d, sel: rdy, last: l});
    step();
  endtask

  always @(negedge clk) begin
    if (rst_n && if0.out_valid_o && if0.out_ready_i) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL beat0: unexpected beat data=%h sel=%b", if0.out_data_o, if0.out_sel_oh_o);
      end else begin
        mon_e = q0.pop_front();
        if (if0.out_data_o !== mon_e.data || if0.out_sel_oh_o !== mon_e.sel
`ifdef RR_ARB_MUX_LOCK_EN
            || if0.out_last_o !== mon_e.last
`endif
           ) begin
          n_err++;
          $display("FAIL beat0: got data=%h sel=%b required data=%h sel=%b last=%b",
                   if0.out_data_o, if0.out_sel_oh_o, mon_e.data, mon_e.sel, mon_e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if1.out_valid_o && if1.out_ready_i) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL beat1: unexpected beat data=%h", if1.out_data_o);
      end else begin
        mon_d = q1.pop_front();
        if (if1.out_data_o !== mon_d || if1.out_sel_oh_o !== 1'b1) begin
          n_err++;
          $display("FAIL beat1: got data=%h sel=%b required data=%h sel=1",
                   if1.out_data_o, if1.out_sel_oh_o, mon_d);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    if0.in_valid_i = 4'b1111;
    if0.in_data_i[0] = 8'hA0;
    if0.in_data_i[1] = 8'hA1;
    if0.in_data_i[2] = 8'hA2;
    if0.in_data_i[3] = 8'hA3;
    if0.out_ready_i = 1'b1;
    if1.in_valid_i = 1'b0;
    if1.in_data_i[0] = 8'h00;
    if1.out_ready_i = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
    if0.in_last_i = 4'b1111;
    if1.in_last_i = 1'b1;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(if0.out_valid_o), 32'd0);
    chk("rst_out_data", 32'(if0.out_data_o), 32'h00);
    chk("rst_out_sel", 32'(if0.out_sel_oh_o), 32'h0);
    chk("rst_in_ready", 32'(if0.in_ready_o), 32'h0);
    step();
    rst_n = 1'b1;

    // Round-robin with every channel requesting.
    expect_grant(4'b0001, 8'hA0, 1'b1);
    expect_grant(4'b0010, 8'hA1, 1'b1);
    expect_grant(4'b0100, 8'hA2, 1'b1);
    expect_grant(4'b1000, 8'hA3, 1'b1);
    expect_grant(4'b0001, 8'hA0, 1'b1);

    // Back-pressure with ch2 requesting.
    if0.in_valid_i = 4'b0100;
    if0.in_data_i[2] = 8'hC2;
    expect_grant(4'b0100, 8'hC2, 1'b1);
    if0.in_data_i[2] = 8'hC3;
    if0.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(if0.in_ready_o), 32'h0);
      chk("bp_out_data", 32'(if0.out_data_o), 32'hC2);
      chk("bp_out_valid", 32'(if0.out_valid_o), 32'd1);
      step();
    end
    if0.out_ready_i = 1'b1;
    expect_grant(4'b0100, 8'hC3, 1'b1);

    // Sparse: pointer at ch3, only ch1 valid.
    if0.in_valid_i = 4'b0010;
    if0.in_data_i[1] = 8'h55;
    expect_grant(4'b0010, 8'h55, 1'b1);

    // Pointer should now sit at ch2.
    if0.in_valid_i = 4'b1111;
    if0.in_data_i[0] = 8'hB0;
    if0.in_data_i[1] = 8'hB1;
    if0.in_data_i[2] = 8'hB2;
    if0.in_data_i[3] = 8'hB3;
    expect_grant(4'b0100, 8'hB2, 1'b1);
    if0.in_valid_i = 4'b0000;
    step();

    // Reset while a beat is held; pointer was at ch1 before the reset.
    if0.in_valid_i = 4'b0001;
    if0.in_data_i[0] = 8'h77;
    if0.out_ready_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(if0.in_ready_o), 32'h1);
    step();
    if0.in_valid_i = 4'b1111;
    if0.in_data_i[0] = 8'hD0;
    if0.in_data_i[1] = 8'hD1;
    if0.in_data_i[2] = 8'hD2;
    if0.in_data_i[3] = 8'hD3;
    @(negedge clk);
    chk("held_out_valid", 32'(if0.out_valid_o), 32'd1);
    chk("held_out_data", 32'(if0.out_data_o), 32'h77);
    chk("held_out_sel", 32'(if0.out_sel_oh_o), 32'h1);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(if0.out_valid_o), 32'd0);
    chk("mid_rst_out_data", 32'(if0.out_data_o), 32'h00);
    chk("mid_rst_out_sel", 32'(if0.out_sel_oh_o), 32'h0);
    chk("mid_rst_in_ready", 32'(if0.in_ready_o), 32'h0);
    step();
    rst_n = 1'b1;
    if0.out_ready_i = 1'b1;
    expect_grant(4'b0001, 8'hD0, 1'b1);

`ifdef RR_ARB_MUX_LOCK_EN
    // ch1 sends a 3-beat packet while ch0 and ch2 also request.
    if0.in_valid_i = 4'b0111;
    if0.in_data_i[0] = 8'hE0;
    if0.in_data_i[1] = 8'h11;
    if0.in_data_i[2] = 8'hE2;
    if0.in_last_i = 4'b0101;
    expect_grant(4'b0010, 8'h11, 1'b0);
    if0.in_data_i[1] = 8'h12;
    expect_grant(4'b0010, 8'h12, 1'b0);
    if0.in_data_i[1] = 8'h13;
    if0.in_last_i = 4'b0111;
    expect_grant(4'b0010, 8'h13, 1'b1);
    expect_grant(4'b0100, 8'hE2, 1'b1);
    if0.in_last_i = 4'b1111;
`endif
    if0.in_valid_i = 4'b0000;
    step();

    // Single-channel instance: ordered stream under random back-pressure.
    for (int v = 1; v <= 16; v++) begin
      acc = 1'b0;
      waitc = 0;
      if1.in_valid_i = 1'b1;
      if1.in_data_i[0] = 8'(v);
      while (!acc) begin
        if1.out_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (if1.in_ready_o[0]) begin
          q1.push_back(8'(v));
          acc = 1'b1;
        end
        step();
        waitc++;
        if (!acc && waitc > 50) begin
          n_vec++;
          n_err++;
          $display("FAIL ch1_accept: beat %0d not accepted within 50 cycles", v);
          acc = 1'b1;
        end
      end
    end
    if1.in_valid_i = 1'b0;
    if1.out_ready_i = 1'b1;
    for (int i = 0; i < 10 && q1.size() != 0; i++) step();

    repeat (3) step();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
